data_memory_bytelane: RTL and testbench

//  Parametrised byte-addressed data memory for the MIPS datapath (MEM stage).

---
 rtl/data_memory_bytelane.sv | 164 ++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressed little-endian data memory with a post-reset clear sequence and a fixed-latency
// response pipe. Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_bytelane #(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              rsp_valid_o,
    output logic [31:0]       data_o,
    output logic              err_o
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned PTR_W = ADDR_W - 2;

    typedef enum logic {StClear, StReady} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [7:0]         mem_q [DEPTH_BYTES];

    logic               accept;
    logic               misaligned;
    logic [3:0]         lane_en;
    logic [ADDR_W-1:0]  lane_addr [4];
    logic [31:0]        rd_word;
    logic [31:0]        ld_data;
    logic [31:0]        rsp_data_in;

    logic               s_valid;
    logic [31:0]        s_data;
    logic               s_err;

    logic               rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == StClear) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == PTR_W'(WORDS - 1)) begin
                state_d = StReady;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign req_ready_o = (state_q == StReady);
    assign accept      = req_valid_i & req_ready_o;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((req_size_i == 2'b01) & addr_i[0]) | (req_size_i[1] & (|addr_i[1:0]));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        unique case (req_size_i)
            2'b00:   lane_en = 4'b0001;
            2'b01:   lane_en = 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        // Lane addresses wrap naturally modulo the array size.
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_i + ADDR_W'(k);
        end
        rd_word = {mem_q[lane_addr[3]], mem_q[lane_addr[2]],
                   mem_q[lane_addr[1]], mem_q[lane_addr[0]]};
    end

    always_comb begin
        unique case (req_size_i)
            2'b00:   ld_data = {{24{~req_unsigned_i & rd_word[7]}}, rd_word[7:0]};
            2'b01:   ld_data = {{16{~req_unsigned_i & rd_word[15]}}, rd_word[15:0]};
            default: ld_data = rd_word;
        endcase
        rsp_data_in = (req_we_i | misaligned) ? 32'h0 : ld_data;
    end

    // Array has no reset; the CLEAR state zeroes it one word per cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{clr_ptr_q, 2'(k)}] <= 8'h00;
            end
        end else if (accept && req_we_i && !misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem_q[lane_addr[k]] <= data_i[8*k +: 8];
                end
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        s_valid_q;
            logic [31:0] s_data_q;
            logic        s_err_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    s_valid_q <= 1'b0;
                    s_data_q  <= 32'h0;
                    s_err_q   <= 1'b0;
                end else begin
                    s_valid_q <= accept;
                    if (accept) begin
                        s_data_q <= rsp_data_in;
                        s_err_q  <= misaligned;
                    end
                end
            end

            assign s_valid = s_valid_q;
            assign s_data  = s_data_q;
            assign s_err   = s_err_q;
        end else begin : g_lat1
            assign s_valid = accept;
            assign s_data  = rsp_data_in;
            assign s_err   = misaligned;
        end
    endgenerate

    // Output stage holds data_o between responses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= s_valid;
            if (s_valid) begin
                rsp_data_q <= s_data;
                rsp_err_q  <= s_err;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign data_o      = rsp_data_q;
    assign err_o       = rsp_err_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomised bench for data_memory_bytelane: READ_LAT=1 and READ_LAT=2 instances share stimulus
// and are compared against a byte-array reference model with a per-cycle response history.
module tb_data_memory_bytelane;

    localparam int DB = 128;
    localparam int AW = 7;
    localparam int HN = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_uns = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;

    logic          ready1, rv1, e1, ready2, rv2, e2;
    logic [31:0]   d1, d2;

    always #5 clk = ~clk;

    data_memory_bytelane #(.DEPTH_BYTES(DB), .ADDR_W(AW), .READ_LAT(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready1),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .addr_i(addr),
        .data_i(wdata), .rsp_valid_o(rv1), .data_o(d1), .err_o(e1)
    );

    data_memory_bytelane #(.DEPTH_BYTES(DB), .ADDR_W(AW), .READ_LAT(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready2),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .addr_i(addr),
        .data_i(wdata), .rsp_valid_o(rv2), .data_o(d2), .err_o(e2)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]  mref [DB];
    int          clr_cnt = 0;
    int          n = 2;
    bit          hv [HN];
    logic [31:0] hd [HN];
    bit          he [HN];
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one accepted request, recorded against edge index n.
    task automatic model_access();
        int          nb;
        bit          mis;
        logic [31:0] v;
        nb  = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (nb == 2 && (addr % 2) != 0) || (nb == 4 && (addr % 4) != 0);
`endif
        v = '0;
        if (req_we) begin
            if (!mis) begin
                for (int k = 0; k < nb; k++) mref[(int'(addr) + k) % DB] = wdata[8*k +: 8];
            end
        end else if (!mis) begin
            for (int k = 0; k < nb; k++) v[8*k +: 8] = mref[(int'(addr) + k) % DB];
            if (!req_uns && nb < 4 && v[8*nb-1]) begin
                for (int b = 8 * nb; b < 32; b++) v[b] = 1'b1;
            end
        end
        hv[n] = 1'b1;
        hd[n] = v;
        he[n] = mis;
    endtask

    task automatic step();
        bit rdy;
        rdy = (clr_cnt >= DB / 4);
        check_eq("ready_lat1", ready1, rdy);
        check_eq("ready_lat2", ready2, rdy);
        @(posedge clk);
        hv[n] = 1'b0;
        hd[n] = '0;
        he[n] = 1'b0;
        if (!rdy) clr_cnt++;
        else if (req_valid) model_access();
        n++;
        @(negedge clk);
        check_eq("rsp_valid_lat1", rv1, hv[n-1]);
        if (hv[n-1]) begin
            last1 = hd[n-1];
            check_eq("err_lat1", e1, he[n-1]);
        end
        check_eq("data_lat1", d1, last1);
        check_eq("rsp_valid_lat2", rv2, hv[n-2]);
        if (hv[n-2]) begin
            last2 = hd[n-2];
            check_eq("err_lat2", e2, he[n-2]);
        end
        check_eq("data_lat2", d2, last2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid1", rv1, 0);
        check_eq("rst_data1", d1, 0);
        check_eq("rst_err1", e1, 0);
        check_eq("rst_ready1", ready1, 0);
        check_eq("rst_valid2", rv2, 0);
        check_eq("rst_data2", d2, 0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_cnt = 0;
        hv[n-1] = 1'b0;
        hv[n-2] = 1'b0;
        last1 = '0;
        last2 = '0;
        for (int i = 0; i < DB; i++) mref[i] = 8'h00;
    endtask

    task automatic rand_fields();
        req_valid = ($urandom_range(0, 9) < 7);
        req_we    = $urandom_range(0, 1);
        req_size  = 2'($urandom_range(0, 3));
        req_uns   = $urandom_range(0, 1);
        addr      = AW'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? AW'(7'h70) : AW'(0));
        wdata     = $urandom;
    endtask

    // Random requests during CLEAR must be ignored.
    task automatic clear_wait();
        repeat (DB / 4) begin
            rand_fields();
            step();
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic req(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        addr      = a;
        wdata     = d;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        clear_wait();

        req(1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);
        check_eq("lw_7c_after_clear", d1, 32'h0);

        req(1'b1, 2'b10, 1'b0, 7'h10, 32'hDEADBEEF);
        req(1'b0, 2'b00, 1'b0, 7'h11, 32'h0);
        check_eq("lb_11", d1, 32'hFFFFFFBE);
        req(1'b0, 2'b00, 1'b1, 7'h11, 32'h0);
        check_eq("lbu_11", d1, 32'h000000BE);
        req(1'b0, 2'b01, 1'b0, 7'h12, 32'h0);
        check_eq("lh_12", d1, 32'hFFFFDEAD);
        req(1'b0, 2'b01, 1'b1, 7'h12, 32'h0);
        check_eq("lhu_12", d1, 32'h0000DEAD);

        req(1'b1, 2'b10, 1'b0, 7'h20, 32'h11223344);
        req(1'b1, 2'b00, 1'b0, 7'h21, 32'h000000AA);
        req(1'b0, 2'b10, 1'b0, 7'h20, 32'h0);
        check_eq("lw_20_merge", d1, 32'h1122AA44);

        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] a;
            a = AW'(7'h30 + 4 * $urandom_range(0, 7));
            req(1'b1, 2'b10, 1'b0, a, $urandom);
            req(1'b0, 2'b10, 1'b0, a, 32'h0);
        end
        step();
        step();

        req(1'b1, 2'b10, 1'b0, 7'h7E, 32'h01020304);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("mis_err", e1, 1);
        check_eq("mis_data", d1, 32'h0);
        req(1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);
        check_eq("mis_unchanged", d1, 32'h0);
`else
        req(1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);
        check_eq("wrap_hi", d1[31:16], 32'h0304);
        req(1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
        check_eq("wrap_lo", d1[15:0], 32'h0102);
`endif
        step();

        req(1'b1, 2'b10, 1'b0, 7'h40, 32'h00000055);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        addr      = 7'h40;
        @(posedge clk);
        #2;
        do_reset();
        clear_wait();
        req(1'b0, 2'b10, 1'b0, 7'h40, 32'h0);
        check_eq("lw_40_after_rst", d1, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                clear_wait();
            end
            rand_fields();
            step();
        end
        req_valid = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
